// File: rtl/viterbi_ctrl_pkg.sv
// Shared types and defaults for the Viterbi frame sequencer.
// Warm-up depth is derived from survivor-history depth and group size.
package viterbi_ctrl_pkg;

  localparam int unsigned B_LEN_DEF      = 2;
  localparam int unsigned SH_DEPTH_DEF   = 18;
  localparam int unsigned WARMUP_GRP_DEF = (SH_DEPTH_DEF + B_LEN_DEF - 1) / B_LEN_DEF;
  localparam int unsigned LEN_W_DEF      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } vfc_state_t;

endpackage

// File: rtl/vfc_group_counter.sv
// Group counter with synchronous clear, increment and a "next step hits limit" flag.
module vfc_group_counter #(
  parameter int unsigned CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             last_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign last_c = (cnt_q + CNT_W'(1)) == limit;

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the Viterbi core: clear, paced advances, warm-up suppression,
// zero-padded drain, and channel-estimate reloads granted only between frames.
module viterbi_frame_ctrl
  import viterbi_ctrl_pkg::*;
#(
  parameter int unsigned B_LEN      = B_LEN_DEF,
  parameter int unsigned WARMUP_GRP = WARMUP_GRP_DEF,
  parameter int unsigned LEN_W      = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             core_en,
  output logic             core_pad,
  output logic             core_clr,
  output logic             out_valid,
  input  logic             chan_upd_req,
  output logic             chan_load,
  output logic             chan_upd_ack,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = LEN_W + 1;

  vfc_state_t       state_q, state_d;
  logic             start_pend_q, start_pend_d;
  logic [LEN_W-1:0] pend_len_q, pend_len_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             out_valid_q, out_valid_d;
  logic             core_clr_q, core_clr_d;
  logic             chan_load_q, chan_load_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] in_cnt, adv_cnt, len_ext, drain_target;
  logic             in_last_c, adv_last_c, abort_hit_c;
  logic             unused_blen_c;

  assign len_ext      = CNT_W'(len_q);
  assign drain_target = len_ext + CNT_W'(WARMUP_GRP);
  assign abort_hit_c  = abort && (state_q inside {ST_CLEAR, ST_RUN, ST_DRAIN});
  assign unused_blen_c = |B_LEN;

  vfc_group_counter #(.CNT_W(CNT_W)) u_in_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == ST_CLEAR),
    .inc    (core_en && (state_q == ST_RUN)),
    .limit  (len_ext),
    .cnt    (in_cnt),
    .last_c (in_last_c)
  );

  vfc_group_counter #(.CNT_W(CNT_W)) u_adv_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == ST_CLEAR),
    .inc    (core_en),
    .limit  (drain_target),
    .cnt    (adv_cnt),
    .last_c (adv_last_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      start_pend_q <= 1'b0;
      pend_len_q   <= '0;
      len_q        <= '0;
      out_valid_q  <= 1'b0;
      core_clr_q   <= 1'b0;
      chan_load_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_pend_q <= start_pend_d;
      pend_len_q   <= pend_len_d;
      len_q        <= len_d;
      out_valid_q  <= out_valid_d;
      core_clr_q   <= core_clr_d;
      chan_load_q  <= chan_load_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next state; channel reload wins over a pending start while idle
  always_comb begin
    state_d      = state_q;
    start_pend_d = start_pend_q;
    pend_len_d   = pend_len_q;
    len_d        = len_q;
    case (state_q)
      ST_IDLE: begin
        if (chan_upd_req) begin
          state_d = ST_LOAD;
        end else if (start_pend_q) begin
          state_d      = ST_CLEAR;
          start_pend_d = 1'b0;
          len_d        = pend_len_q;
        end
      end
      ST_LOAD: state_d = ST_IDLE;
      ST_CLEAR: begin
        if (abort)              state_d = ST_IDLE;
        else if (len_q == '0)   state_d = ST_DONE;
        else                    state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (core_en && in_last_c) begin
          state_d = (WARMUP_GRP == 0) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort)                      state_d = ST_IDLE;
        else if (core_en && adv_last_c) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A new start always lands in the one-deep pending slot
    if (start) begin
      start_pend_d = 1'b1;
      pend_len_d   = frame_len;
    end
  end

  // Outputs; abort blocks the advance in its own cycle so nothing new becomes valid
  always_comb begin
    in_ready = 1'b0;
    core_en  = 1'b0;
    core_pad = 1'b0;
    case (state_q)
      ST_RUN: begin
        in_ready = out_ready && (in_cnt < len_ext) && !abort;
        core_en  = in_valid && in_ready;
      end
      ST_DRAIN: begin
        core_en  = out_ready && !abort;
        core_pad = core_en;
      end
      default: ;
    endcase
    out_valid_d = core_en && (adv_cnt >= CNT_W'(WARMUP_GRP));
    core_clr_d  = (state_d == ST_CLEAR) || abort_hit_c;
    chan_load_d = (state_d == ST_LOAD);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  assign out_valid    = out_valid_q;
  assign core_clr     = core_clr_q;
  assign chan_load    = chan_load_q;
  assign chan_upd_ack = chan_load_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed bench for viterbi_frame_ctrl with a 3-group warm-up.
module tb_viterbi_frame_ctrl;

  localparam int unsigned LEN_W = 16;

  logic             clk, rst, start, abort, in_valid, out_ready, chan_upd_req;
  logic [LEN_W-1:0] frame_len;
  logic             in_ready, core_en, core_pad, core_clr, out_valid;
  logic             chan_load, chan_upd_ack, busy, done;
  logic [8:0]       all_outs;

  int checks;
  int errors;

  assign all_outs = {in_ready, core_en, core_pad, core_clr, out_valid,
                     chan_load, chan_upd_ack, busy, done};

  viterbi_frame_ctrl #(.B_LEN(2), .WARMUP_GRP(3), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .frame_len    (frame_len),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_ready    (out_ready),
    .core_en      (core_en),
    .core_pad     (core_pad),
    .core_clr     (core_clr),
    .out_valid    (out_valid),
    .chan_upd_req (chan_upd_req),
    .chan_load    (chan_load),
    .chan_upd_ack (chan_upd_ack),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [LEN_W-1:0] len);
    start     = 1'b1;
    frame_len = len;
    tick();
    start     = 1'b0;
  endtask

  // Runs cycles until done is seen (or budget expires) and tallies activity
  task automatic observe(input int budget, output int n_en, output int n_pad,
                         output int n_ov, output int n_clr, output int first_ov_at,
                         output int first_pad_at, output int clr_cyc,
                         output int done_cyc, output bit ov_at_done);
    n_en = 0; n_pad = 0; n_ov = 0; n_clr = 0;
    first_ov_at = -1; first_pad_at = -1; clr_cyc = -1; done_cyc = -1; ov_at_done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      #2;
      if (core_clr) begin n_clr++; clr_cyc = c; end
      if (out_valid && first_ov_at < 0) first_ov_at = n_en;
      if (core_pad && first_pad_at < 0) first_pad_at = n_en;
      if (out_valid) n_ov++;
      if (core_en) n_en++;
      if (core_pad) n_pad++;
      if (done) begin done_cyc = c; ov_at_done = out_valid; end
      tick();
      if (done_cyc >= 0) break;
    end
  endtask

  task automatic wait_adv(input int want, output int got);
    got = 0;
    for (int c = 0; c < 20 && got < want; c++) begin
      #2;
      if (core_en) got++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; frame_len = '0;
    in_valid = 1'b1; out_ready = 1'b1; chan_upd_req = 1'b0;
    #1 rst = 1'b1;
    #2;
    checks++;
    if (all_outs !== 9'd0) begin errors++; $display("FAIL reset_outs got %b want 0", all_outs); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    tick(); tick();
    #2;
    checks++;
    if (all_outs !== 9'd0) begin errors++; $display("FAIL idle_outs got %b want 0", all_outs); end
    tick();
  endtask

  task automatic test_basic();
    int n_en, n_pad, n_ov, n_clr, fov, fpad, cc, dc; bit ovd;
    pulse_start(16'd4);
    observe(40, n_en, n_pad, n_ov, n_clr, fov, fpad, cc, dc, ovd);
    checks++; if (dc < 0)     begin errors++; $display("FAIL basic_done got none want done"); end
    checks++; if (n_clr != 1) begin errors++; $display("FAIL basic_clr got %0d want 1", n_clr); end
    checks++; if (n_en != 7)  begin errors++; $display("FAIL basic_en got %0d want 7", n_en); end
    checks++; if (n_pad != 3) begin errors++; $display("FAIL basic_pad got %0d want 3", n_pad); end
    checks++; if (fpad != 4)  begin errors++; $display("FAIL basic_first_pad got %0d want 4", fpad); end
    checks++; if (n_ov != 4)  begin errors++; $display("FAIL basic_ov got %0d want 4", n_ov); end
    checks++; if (fov != 4)   begin errors++; $display("FAIL basic_first_ov got %0d want 4", fov); end
    checks++; if (!ovd)       begin errors++; $display("FAIL basic_ov_at_done got 0 want 1"); end
    checks++; if (dc - cc != 8) begin errors++; $display("FAIL basic_latency got %0d want 8", dc - cc); end
  endtask

  task automatic test_short();
    int n_en, n_pad, n_ov, n_clr, fov, fpad, cc, dc; bit ovd;
    pulse_start(16'd2);
    observe(40, n_en, n_pad, n_ov, n_clr, fov, fpad, cc, dc, ovd);
    checks++; if (dc < 0)     begin errors++; $display("FAIL short_done got none want done"); end
    checks++; if (n_en != 5)  begin errors++; $display("FAIL short_en got %0d want 5", n_en); end
    checks++; if (n_pad != 3) begin errors++; $display("FAIL short_pad got %0d want 3", n_pad); end
    checks++; if (n_ov != 2)  begin errors++; $display("FAIL short_ov got %0d want 2", n_ov); end
    checks++; if (fov != 4)   begin errors++; $display("FAIL short_first_ov got %0d want 4", fov); end
    checks++; if (!ovd)       begin errors++; $display("FAIL short_ov_at_done got 0 want 1"); end
  endtask

  task automatic test_stall();
    int n_en, n_pad, n_ov, n_clr, fov, fpad, cc, dc, got, bad; bit ovd;
    pulse_start(16'd4);
    wait_adv(2, got);
    checks++; if (got != 2) begin errors++; $display("FAIL stall_pre got %0d want 2", got); end
    out_ready = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      #2;
      if (core_en || in_ready || !busy) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold got %0d bad cycles want 0", bad); end
    out_ready = 1'b1;
    observe(40, n_en, n_pad, n_ov, n_clr, fov, fpad, cc, dc, ovd);
    checks++; if (dc < 0)     begin errors++; $display("FAIL stall_done got none want done"); end
    checks++; if (n_en != 5)  begin errors++; $display("FAIL stall_en got %0d want 5", n_en); end
    checks++; if (n_ov != 4)  begin errors++; $display("FAIL stall_ov got %0d want 4", n_ov); end
    checks++; if (fov != 2)   begin errors++; $display("FAIL stall_first_ov got %0d want 2", fov); end
  endtask

  task automatic test_chan();
    int n_load, n_ack, load_cyc, ack_cyc, done_cyc, clr_cyc;
    n_load = 0; n_ack = 0; load_cyc = -1; ack_cyc = -1; done_cyc = -1; clr_cyc = -1;
    pulse_start(16'd2);
    for (int c = 0; c < 20; c++) begin
      if (c == 3) chan_upd_req = 1'b1;
      #2;
      if (chan_load) begin n_load++; load_cyc = c; end
      if (chan_upd_ack) begin n_ack++; ack_cyc = c; end
      if (done) done_cyc = c;
      tick();
      if (load_cyc >= 0) chan_upd_req = 1'b0;
    end
    checks++; if (done_cyc < 0) begin errors++; $display("FAIL chan_done got none want done"); end
    checks++; if (n_load != 1)  begin errors++; $display("FAIL chan_load_cnt got %0d want 1", n_load); end
    checks++; if (n_ack != 1)   begin errors++; $display("FAIL chan_ack_cnt got %0d want 1", n_ack); end
    checks++; if (load_cyc != done_cyc + 2) begin
      errors++; $display("FAIL chan_load_cyc got %0d want %0d", load_cyc, done_cyc + 2);
    end
    checks++; if (ack_cyc != load_cyc) begin errors++; $display("FAIL chan_ack_cyc got %0d want %0d", ack_cyc, load_cyc); end

    // Simultaneous request and start: reload first, then the frame
    load_cyc = -1; done_cyc = -1;
    start = 1'b1; frame_len = 16'd1; chan_upd_req = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #2;
      if (chan_load && load_cyc < 0) load_cyc = c;
      if (core_clr && clr_cyc < 0) clr_cyc = c;
      if (done) done_cyc = c;
      tick();
      if (load_cyc >= 0) chan_upd_req = 1'b0;
    end
    checks++; if (load_cyc != 0) begin errors++; $display("FAIL prio_load_cyc got %0d want 0", load_cyc); end
    checks++; if (clr_cyc != 2)  begin errors++; $display("FAIL prio_clr_cyc got %0d want 2", clr_cyc); end
    checks++; if (done_cyc != 7) begin errors++; $display("FAIL prio_done_cyc got %0d want 7", done_cyc); end
  endtask

  task automatic test_abort();
    int n_en, n_pad, n_ov, n_clr, fov, fpad, cc, dc, got, act; bit ovd;
    pulse_start(16'd4);
    wait_adv(2, got);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    #2;
    checks++; if (core_clr !== 1'b1) begin errors++; $display("FAIL abort_clr got %b want 1", core_clr); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    tick();
    act = 0;
    for (int c = 0; c < 15; c++) begin
      #2;
      if (done || core_en || core_clr || out_valid || busy) act++;
      tick();
    end
    checks++; if (act != 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles want 0", act); end
    pulse_start(16'd4);
    observe(40, n_en, n_pad, n_ov, n_clr, fov, fpad, cc, dc, ovd);
    checks++; if (dc < 0)    begin errors++; $display("FAIL abort_restart_done got none want done"); end
    checks++; if (n_en != 7) begin errors++; $display("FAIL abort_restart_en got %0d want 7", n_en); end
    checks++; if (n_ov != 4) begin errors++; $display("FAIL abort_restart_ov got %0d want 4", n_ov); end
  endtask

  task automatic test_len0();
    int n_en, n_pad, n_ov, n_clr, fov, fpad, cc, dc; bit ovd;
    pulse_start(16'd0);
    observe(20, n_en, n_pad, n_ov, n_clr, fov, fpad, cc, dc, ovd);
    checks++; if (dc < 0)     begin errors++; $display("FAIL len0_done got none want done"); end
    checks++; if (n_clr != 1) begin errors++; $display("FAIL len0_clr got %0d want 1", n_clr); end
    checks++; if (n_en != 0)  begin errors++; $display("FAIL len0_en got %0d want 0", n_en); end
    checks++; if (n_ov != 0)  begin errors++; $display("FAIL len0_ov got %0d want 0", n_ov); end
    checks++; if (dc - cc != 1) begin errors++; $display("FAIL len0_latency got %0d want 1", dc - cc); end
  endtask

  task automatic test_back_to_back();
    int n_en, n_pad, n_ov, n_clr, fov, fpad, cc, dc; bit ovd;
    pulse_start(16'd2);
    tick();
    pulse_start(16'd1);
    observe(40, n_en, n_pad, n_ov, n_clr, fov, fpad, cc, dc, ovd);
    checks++; if (dc < 0)    begin errors++; $display("FAIL b2b_first_done got none want done"); end
    checks++; if (n_en != 5) begin errors++; $display("FAIL b2b_first_en got %0d want 5", n_en); end
    checks++; if (n_ov != 2) begin errors++; $display("FAIL b2b_first_ov got %0d want 2", n_ov); end
    observe(40, n_en, n_pad, n_ov, n_clr, fov, fpad, cc, dc, ovd);
    checks++; if (dc < 0)     begin errors++; $display("FAIL b2b_second_done got none want done"); end
    checks++; if (n_clr != 1) begin errors++; $display("FAIL b2b_second_clr got %0d want 1", n_clr); end
    checks++; if (n_en != 4)  begin errors++; $display("FAIL b2b_second_en got %0d want 4", n_en); end
    checks++; if (n_ov != 1)  begin errors++; $display("FAIL b2b_second_ov got %0d want 1", n_ov); end
  endtask

  task automatic test_rst_mid();
    int got, bad;
    pulse_start(16'd4);
    wait_adv(2, got);
    start = 1'b1; frame_len = 16'd3;
    tick();
    start = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++; if (all_outs !== 9'd0) begin errors++; $display("FAIL rst_mid_outs got %b want 0", all_outs); end
    tick();
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      #2;
      if (busy || core_en || core_clr) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid_pend got %0d busy cycles want 0", bad); end
  endtask

  initial begin
    clk = 1'b0;
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_short();
    test_stall();
    test_chan();
    test_abort();
    test_len0();
    test_back_to_back();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
